// File: rtl/main_memory.sv
//==============================================================================
// Module  : main_memory
// Purpose : Word-addressed 32-bit memory returning 4-word blocks after a fixed
//           latency, with an independent single-word write port.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module main_memory #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 32768
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         memRead,
    input  logic [14:0]  memReadAddress,
    output logic         ready,
    output logic [127:0] dataOut,
    output logic         dataValid,
    input  logic         memWrite,
    input  logic [14:0]  writeAddress,
    input  logic [31:0]  writeData
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [3:0]    counter;
    logic [14:0]   block_addr;
    logic [127:0]  block_data;
    logic [31:0]   mem [DEPTH];

    // Array contents survive reset, so the write port has no reset branch.
    always_ff @(posedge clock) begin
        if (memWrite) begin
            mem[writeAddress[AW-1:0]] <= writeData;
        end
    end

    // A write landing on the same edge as the block load must appear in the
    // response, hence the per-word bypass from the write port.
    for (genvar k = 0; k < 4; k++) begin : g_word
        logic [14:0] word_addr;
        assign word_addr = block_addr | 15'(k);
        assign block_data[32*k +: 32] =
            (memWrite && (writeAddress[AW-1:0] == word_addr[AW-1:0]))
                ? writeData : mem[word_addr[AW-1:0]];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        dataValid  = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (memRead) begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (counter == 4'd0) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                dataValid  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            counter    <= 4'd0;
            block_addr <= 15'd0;
            dataOut    <= 128'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (memRead) begin
                        block_addr <= memReadAddress & 15'h7FFC;
                        counter    <= LAT_LOAD;
                    end
                end
                BUSY: begin
                    if (counter != 4'd0) begin
                        counter <= counter - 4'd1;
                    end else begin
                        dataOut <= block_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_main_memory.sv
//==============================================================================
// Module  : tb_main_memory
// Purpose : Randomized and directed bench for main_memory against a
//           timeline-based reference model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_main_memory;

    parameter int LATENCY = 4;
    localparam int DEPTH  = 32768;

    logic         clock;
    logic         reset_n;
    logic         memRead;
    logic [14:0]  memReadAddress;
    logic         ready;
    logic [127:0] dataOut;
    logic         dataValid;
    logic         memWrite;
    logic [14:0]  writeAddress;
    logic [31:0]  writeData;

    main_memory #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .memRead        (memRead),
        .memReadAddress (memReadAddress),
        .ready          (ready),
        .dataOut        (dataOut),
        .dataValid      (dataValid),
        .memWrite       (memWrite),
        .writeAddress   (writeAddress),
        .writeData      (writeData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a request accepted at edge A is answered from the
    // memory image as it stands after edge A+LATENCY, and the next request can
    // be taken no earlier than edge A+LATENCY+2.
    logic [31:0]  mmem [DEPTH];
    bit           in_flight = 1'b0;
    int unsigned  edge_n    = 0;
    int unsigned  acc_edge  = 0;
    logic [14:0]  acc_base  = '0;
    logic         exp_valid = 1'b0;
    logic         exp_ready = 1'b1;
    logic [127:0] exp_dout  = '0;

    task automatic model_step();
        edge_n++;
        exp_valid = 1'b0;
        if (memWrite) mmem[writeAddress] = writeData;
        if (in_flight && edge_n == acc_edge + LATENCY) begin
            exp_dout  = {mmem[acc_base + 15'd3], mmem[acc_base + 15'd2],
                         mmem[acc_base + 15'd1], mmem[acc_base]};
            exp_valid = 1'b1;
        end
        if (in_flight && edge_n == acc_edge + LATENCY + 1) begin
            in_flight = 1'b0;
        end else if (!in_flight && memRead) begin
            in_flight = 1'b1;
            acc_edge  = edge_n;
            acc_base  = memReadAddress & 15'h7FFC;
        end
        exp_ready = !in_flight;
    endtask

    task automatic model_reset();
        in_flight = 1'b0;
        exp_valid = 1'b0;
        exp_ready = 1'b1;
        exp_dout  = '0;
    endtask

    task automatic cyc();
        @(posedge clock);
        if (reset_n) model_step();
        @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            check("ready", {127'd0, ready}, {127'd0, exp_ready});
            check("dataValid", {127'd0, dataValid}, {127'd0, exp_valid});
            check("dataOut", dataOut, exp_dout);
        end
    end

    task automatic wr(input logic [14:0] a, input logic [31:0] d);
        memWrite     = 1'b1;
        writeAddress = a;
        writeData    = d;
        cyc();
        memWrite     = 1'b0;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!ready && k < 64) begin cyc(); k++; end
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!dataValid && k < 64) begin cyc(); k++; end
    endtask

    task automatic read_block(input logic [14:0] a, output int lat);
        wait_ready();
        memRead        = 1'b1;
        memReadAddress = a;
        cyc();
        memRead        = 1'b0;
        wait_valid(lat);
    endtask

    logic [14:0] pool [8] = '{15'h0010, 15'h7FFC, 15'h0100, 15'h1234,
                              15'h4000, 15'h2468, 15'h5550, 15'h0ABC};

    initial begin
        int lat;
        int pulses;
        reset_n = 1'b0; memRead = 1'b0; memReadAddress = '0;
        memWrite = 1'b0; writeAddress = '0; writeData = '0;
        repeat (2) @(negedge clock);
        check("rst_ready", {127'd0, ready}, 128'd1);
        check("rst_valid", {127'd0, dataValid}, 128'd0);
        check("rst_dout", dataOut, 128'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            wr(15'h0010 + 15'(i), 32'hA0 + 32'(i));
            wr(15'h7FFC + 15'(i), 32'hC0 + 32'(i));
        end
        for (int b = 2; b < 8; b++)
            for (int i = 0; i < 4; i++) wr(pool[b] | 15'(i), $urandom);

        read_block(15'h0012, lat);
        check("basic_latency", lat, LATENCY);
        check("basic_data", dataOut, 128'h000000A3_000000A2_000000A1_000000A0);
        cyc();
        check("basic_pulse_width", {127'd0, dataValid}, 128'd0);

        // Write during BUSY is reflected; write after RESP edge is not.
        wait_ready();
        memRead = 1'b1; memReadAddress = 15'h0010;
        cyc();
        memRead = 1'b0;
        wr(15'h0011, 32'h55);
        wait_valid(lat);
        check("busy_write_word1", {96'd0, dataOut[63:32]}, 128'h55);
        wr(15'h0011, 32'h66);
        check("late_write_held", {96'd0, dataOut[63:32]}, 128'h55);

        // Write on the very edge that enters RESP.
        wait_ready();
        memRead = 1'b1; memReadAddress = 15'h0010;
        cyc();
        memRead = 1'b0;
        repeat (LATENCY - 1) cyc();
        wr(15'h0012, 32'h77);
        check("edge_write_valid", {127'd0, dataValid}, 128'd1);
        check("edge_write_data", dataOut, 128'h000000A3_00000077_00000066_000000A0);

        // Accept and write to the same block on one edge.
        wait_ready();
        memRead = 1'b1; memReadAddress = 15'h0013;
        memWrite = 1'b1; writeAddress = 15'h0013; writeData = 32'h88;
        cyc();
        memRead = 1'b0; memWrite = 1'b0;
        wait_valid(lat);
        check("same_edge_write", {96'd0, dataOut[127:96]}, 128'h88);

        // Reset two cycles into BUSY aborts the transaction.
        wait_ready();
        cyc();
        memRead = 1'b1; memReadAddress = 15'h0010;
        cyc();
        memRead = 1'b0;
        repeat (2) cyc();
        reset_n = 1'b0;
        model_reset();
        #1;
        check("abort_ready", {127'd0, ready}, 128'd1);
        check("abort_valid", {127'd0, dataValid}, 128'd0);
        check("abort_dout", dataOut, 128'd0);
        repeat (3) cyc();
        reset_n = 1'b1;
        repeat (LATENCY + 2) cyc();
        read_block(15'h0010, lat);
        check("post_reset_latency", lat, LATENCY);
        check("post_reset_data", dataOut, 128'h00000088_00000077_00000066_000000A0);

        read_block(15'h7FFF, lat);
        check("wrap_data", dataOut, 128'h000000C3_000000C2_000000C1_000000C0);

        // Continuous requests: one pulse per LATENCY+2 cycles.
        wait_ready();
        cyc();
        pulses = 0;
        memRead = 1'b1;
        for (int i = 0; i < 24; i++) begin
            memReadAddress = pool[$urandom_range(7)] | 15'($urandom_range(3));
            cyc();
            if (dataValid) pulses++;
        end
        memRead = 1'b0;
        check("stream_pulses", pulses, (24 - 1 - LATENCY) / (LATENCY + 2) + 1);

        for (int i = 0; i < 3000; i++) begin
            memRead        = ($urandom_range(3) != 0);
            memReadAddress = pool[$urandom_range(7)] | 15'($urandom_range(3));
            memWrite       = ($urandom_range(2) == 0);
            writeAddress   = pool[$urandom_range(7)] | 15'($urandom_range(3));
            writeData      = $urandom;
            cyc();
        end
        memRead = 1'b0; memWrite = 1'b0;
        repeat (LATENCY + 3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
